// File: rtl/seq_restoring_divider_if.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider_if
// Request/result bundle for the sequential restoring divider.
//   start        : operation request, honoured only while busy is low
//   dividend     : n-bit unsigned dividend, captured with an accepted start
//   divisor      : n-bit unsigned divisor, captured with an accepted start
//   busy         : operation in progress
//   done         : one-cycle pulse, results valid in the same cycle
//   quotient     : n-bit result, held until the next result overwrites it
//   remainder    : n-bit result, held until the next result overwrites it
//   div_by_zero  : set alongside the results when the divisor was zero
// The master modport is the requester; the slave modport is the divider.
// ---------------------------------------------------------------------------
interface seq_restoring_divider_if #(
    parameter int n = 4
);
    logic         start;
    logic [n-1:0] dividend;
    logic [n-1:0] divisor;
    logic         busy;
    logic         done;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle unsigned restoring divider: one quotient bit per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears state and all outputs
//   bus  : seq_restoring_divider_if.slave (start/operands in, results out)
// Timing: a start accepted at edge t yields done in the cycle after edge
// t+n+1 (one LOAD cycle plus n CALC cycles); a zero divisor skips CALC and
// yields done in the cycle after edge t+1.
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int n = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_divider_if.slave  bus
);
    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [n-1:0]     d_reg;      // dividend shifting out, quotient shifting in
    logic [n-1:0]     v_reg;      // latched divisor
    logic [n:0]       r_reg;      // partial remainder
    logic [CW-1:0]    cnt;        // completed restoring steps

    logic [n-1:0]     q_out;
    logic [n-1:0]     r_out;
    logic             dz_out;

    logic             accept;
    logic             last_step;
    logic [n:0]       rs;
    logic [n+1:0]     diff;
    logic             borrow;
    logic [n-1:0]     d_step;
    logic [n:0]       r_step;

    // The partial remainder stays below the divisor after every step, so its
    // top bit is always zero; it is kept only to match the subtractor width.
    logic             unused_r_msb;
    assign unused_r_msb = r_reg[n];

    // A new operation may be taken while idle or in the result cycle.
    assign accept    = bus.start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == CALC) && (cnt == CW'(n - 1));

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor through the zero-extended subtractor, and let the borrow decide
    // whether the trial result is kept or the shifted value is restored.
    always_comb begin
        rs     = {r_reg[n-1:0], d_reg[n-1]};
        diff   = {1'b0, rs} - {2'b00, v_reg};
        borrow = diff[n+1];
        d_step = {d_reg[n-2:0], ~borrow};
        r_step = borrow ? rs : diff[n:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = (v_reg == '0) ? DONE : CALC;
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = accept ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg  <= '0;
            v_reg  <= '0;
            r_reg  <= '0;
            cnt    <= '0;
            q_out  <= '0;
            r_out  <= '0;
            dz_out <= 1'b0;
        end else begin
            if (accept) begin
                d_reg <= bus.dividend;
                v_reg <= bus.divisor;
                r_reg <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                d_reg <= d_step;
                r_reg <= r_step;
                cnt   <= cnt + 1'b1;
            end

            // Results are written on the edge that enters DONE so they are
            // already valid while done is high.
            if ((state == LOAD) && (v_reg == '0)) begin
                q_out  <= '1;
                r_out  <= d_reg;
                dz_out <= 1'b1;
            end else if (last_step) begin
                q_out  <= d_step;
                r_out  <= r_step[n-1:0];
                dz_out <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state == LOAD) || (state == CALC);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.div_by_zero = dz_out;

endmodule
